sd_wb_sequencer: RTL and testbench

Wishbone master front-end for the SD controller core's register port. It replaces the hard-wired reset counter and fixed FSM coupling with a parametrised sequencer. The sequencer:
- stretches the controller reset;
- accepts single register operations (write, read, poll-until-match) over a valid/ready request channel;
- runs them as classic Wishbone single cycles, with an ack timeout;
- returns a response with data and status.

It sits between the SD init/read FSM and sdc_controller, inside the SD bus master.

---
 rtl/sd_wb_sequencer_pkg.sv | 40 ++++
 rtl/sd_wb_sequencer_if.sv | 47 ++++
 rtl/sd_wb_sequencer_reset_stretch.sv | 43 ++++
 rtl/sd_wb_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sd_wb_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_wb_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_seq_pkg
// Description : Op/status codes, FSM state type and helpers shared by the
//               SD Wishbone register-port sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_seq_pkg;

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_READ     = 2'b01;
    localparam logic [1:0] OP_POLL     = 2'b10;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [1:0] ST_POLL_EXH = 2'b10;

    localparam logic [3:0] c_wb_sel_all = 4'hF;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        IDLE       = 3'd1,
        BUS        = 3'd2,
        GAP        = 3'd3,
        RESP       = 3'd4
    } seq_state_e;

    // Width of a counter that must hold the values 0 .. max_val-1.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

    function automatic logic poll_hit(input logic [31:0] dat,
                                      input logic [31:0] match,
                                      input logic [31:0] mask);
        return ((dat & mask) == (match & mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_wb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_wb_sequencer_if
// Description : Request/response channel plus Wishbone master bus of the
//               SD register-port sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_wb_sequencer_if #(
    parameter int ADR_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [ADR_W-1:0] req_adr;
    logic [31:0]      req_dat;
    logic [31:0]      req_mask;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_dat;
    logic [1:0]       rsp_status;

    logic [ADR_W-1:0] wb_adr_o;
    logic [31:0]      wb_dat_o;
    logic [31:0]      wb_dat_i;
    logic [3:0]       wb_sel_o;
    logic             wb_we_o;
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_ack_i;

    // Environment view: issues requests, consumes responses, acts as WB slave.
    modport master (
        output req_valid, req_op, req_adr, req_dat, req_mask, rsp_ready,
               wb_dat_i, wb_ack_i,
        input  req_ready, rsp_valid, rsp_dat, rsp_status,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        input  req_valid, req_op, req_adr, req_dat, req_mask, rsp_ready,
               wb_dat_i, wb_ack_i,
        output req_ready, rsp_valid, rsp_dat, rsp_status,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface
`default_nettype wire

// File: rtl/sd_wb_sequencer_reset_stretch.sv
`default_nettype none
// ============================================================================
// Module      : sd_reset_stretch
// Description : Holds core_rst high for RESET_CYCLES edges after reset_n
//               release; rst_done marks the edge on which it drops.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_reset_stretch
    import sd_seq_pkg::*;
#(
    parameter int RESET_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
    output logic      core_rst,
    output logic      rst_done
);

    localparam int                 c_cnt_w = cnt_width(RESET_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(RESET_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_core_rst;

    // Combinational so the sequencer leaves RESET_HOLD on the same edge.
    assign rst_done = r_core_rst && (r_cnt == c_last);
    assign core_rst = r_core_rst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_core_rst <= 1'b1;
        end else if (r_core_rst) begin
            if (r_cnt == c_last) begin
                r_core_rst <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sd_wb_sequencer
// Description : Wishbone master front-end for the SD controller register
//               port: reset stretch, write/read/poll ops with ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_wb_sequencer
    import sd_seq_pkg::*;
#(
    parameter int ADR_W        = 8,
    parameter int RESET_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 256,
    parameter int POLL_LIMIT   = 1024,
    parameter int POLL_GAP     = 16
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    output logic             core_rst,
    output logic             busy,
    sd_wb_sequencer_if.slave bus
);

    localparam int                  c_tmr_w     = cnt_width(ACK_TIMEOUT);
    localparam logic [c_tmr_w-1:0]  c_tmr_last  = c_tmr_w'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam int                  c_poll_w    = cnt_width(POLL_LIMIT);
    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_LIMIT - 1);
    localparam int                  c_gap_w     = cnt_width(POLL_GAP);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    seq_state_e          r_state,      w_state;
    logic                r_req_ready,  w_req_ready;
    logic [ADR_W-1:0]    r_adr,        w_adr;
    logic [31:0]         r_wdat,       w_wdat;
    logic [31:0]         r_mask,       w_mask;
    logic                r_we,         w_we;
    logic                r_poll,       w_poll;
    logic                r_cyc,        w_cyc;
    logic [c_poll_w-1:0] r_poll_cnt,   w_poll_cnt;
    logic [c_tmr_w-1:0]  r_tmr,        w_tmr;
    logic [c_gap_w-1:0]  r_gap_cnt,    w_gap_cnt;
    logic                r_rsp_valid,  w_rsp_valid;
    logic [31:0]         r_rsp_dat,    w_rsp_dat;
    logic [1:0]          r_rsp_status, w_rsp_status;
    logic                w_rst_done;

    sd_reset_stretch #(
        .RESET_CYCLES (RESET_CYCLES)
    ) u_reset_stretch (
        .clk      (clk),
        .reset_n  (reset_n),
        .core_rst (core_rst),
        .rst_done (w_rst_done)
    );

    always_comb begin
        w_state      = r_state;
        w_req_ready  = r_req_ready;
        w_adr        = r_adr;
        w_wdat       = r_wdat;
        w_mask       = r_mask;
        w_we         = r_we;
        w_poll       = r_poll;
        w_cyc        = r_cyc;
        w_poll_cnt   = r_poll_cnt;
        w_tmr        = r_tmr;
        w_gap_cnt    = r_gap_cnt;
        w_rsp_valid  = r_rsp_valid;
        w_rsp_dat    = r_rsp_dat;
        w_rsp_status = r_rsp_status;

        case (r_state)
            RESET_HOLD: begin
                if (w_rst_done) begin
                    w_state     = IDLE;
                    w_req_ready = 1'b1;
                end
            end

            IDLE: begin
                w_req_ready = 1'b1;
                if (r_req_ready && bus.req_valid) begin
                    w_req_ready = 1'b0;
                    w_adr       = bus.req_adr;
                    // wb_dat_o doubles as the poll match value.
                    w_wdat      = bus.req_dat;
                    w_mask      = bus.req_mask;
                    w_we        = (bus.req_op == OP_WRITE);
                    w_poll      = (bus.req_op == OP_POLL);
                    w_poll_cnt  = '0;
                    w_tmr       = '0;
                    w_cyc       = 1'b1;
                    w_state     = BUS;
                end
            end

            BUS: begin
                if (bus.wb_ack_i) begin
                    w_cyc        = 1'b0;
                    w_tmr        = '0;
                    w_rsp_dat    = r_we ? 32'h0 : bus.wb_dat_i;
                    w_rsp_status = ST_OK;
                    if (r_we || !r_poll || poll_hit(bus.wb_dat_i, r_wdat, r_mask)) begin
                        w_rsp_valid = 1'b1;
                        w_state     = RESP;
                    end else if (r_poll_cnt == c_poll_last) begin
                        w_rsp_status = ST_POLL_EXH;
                        w_rsp_valid  = 1'b1;
                        w_state      = RESP;
                    end else begin
                        w_poll_cnt = r_poll_cnt + 1'b1;
                        w_gap_cnt  = '0;
                        w_state    = GAP;
                    end
                end else if ((ACK_TIMEOUT != 0) && (r_tmr == c_tmr_last)) begin
                    w_cyc        = 1'b0;
                    w_tmr        = '0;
                    w_rsp_dat    = 32'h0;
                    w_rsp_status = ST_TIMEOUT;
                    w_rsp_valid  = 1'b1;
                    w_state      = RESP;
                end else begin
                    w_tmr = r_tmr + 1'b1;
                end
            end

            GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_cyc   = 1'b1;
                    w_tmr   = '0;
                    w_state = BUS;
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state     = IDLE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RESET_HOLD;
            r_req_ready  <= 1'b0;
            r_adr        <= '0;
            r_wdat       <= '0;
            r_mask       <= '0;
            r_we         <= 1'b0;
            r_poll       <= 1'b0;
            r_cyc        <= 1'b0;
            r_poll_cnt   <= '0;
            r_tmr        <= '0;
            r_gap_cnt    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            r_state      <= w_state;
            r_req_ready  <= w_req_ready;
            r_adr        <= w_adr;
            r_wdat       <= w_wdat;
            r_mask       <= w_mask;
            r_we         <= w_we;
            r_poll       <= w_poll;
            r_cyc        <= w_cyc;
            r_poll_cnt   <= w_poll_cnt;
            r_tmr        <= w_tmr;
            r_gap_cnt    <= w_gap_cnt;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_dat    <= w_rsp_dat;
            r_rsp_status <= w_rsp_status;
        end
    end

    assign busy           = (r_state != IDLE);
    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_dat    = r_rsp_dat;
    assign bus.rsp_status = r_rsp_status;
    assign bus.wb_adr_o   = r_adr;
    assign bus.wb_dat_o   = r_wdat;
    assign bus.wb_sel_o   = c_wb_sel_all;
    assign bus.wb_we_o    = r_we;
    assign bus.wb_cyc_o   = r_cyc;
    assign bus.wb_stb_o   = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_sd_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_wb_sequencer
// Description : Self-checking bench for sd_wb_sequencer with a response
//               scoreboard and a latency-programmable Wishbone slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_wb_sequencer;
    import sd_seq_pkg::*;

    localparam int ADR_W        = 8;
    localparam int RESET_CYCLES = 4;
    localparam int ACK_TIMEOUT  = 8;
    localparam int POLL_LIMIT   = 3;
    localparam int POLL_GAP     = 2;

    typedef struct packed {
        logic [1:0]  status;
        logic [31:0] dat;
    } rsp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic core_rst;
    logic busy;

    sd_wb_sequencer_if #(.ADR_W(ADR_W)) bus ();

    sd_wb_sequencer #(
        .ADR_W        (ADR_W),
        .RESET_CYCLES (RESET_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .POLL_LIMIT   (POLL_LIMIT),
        .POLL_GAP     (POLL_GAP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .core_rst (core_rst),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    rsp_t        exp_q[$];
    int          ack_lat = 1;
    logic [31:0] rd_q[$];
    int          len_q[$];
    int          gap_q[$];
    int          stab_err = 0;
    logic [ADR_W-1:0] seen_adr;
    logic [31:0]      seen_wdat;
    logic             seen_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one operation given the slave's data and ack latency.
    function automatic rsp_t model(input logic [1:0] op, input logic [31:0] match,
                                   input logic [31:0] mask, input logic [31:0] rd[$],
                                   input int lat);
        logic [31:0] last;
        last = 32'h0;
        if (lat == 0 || lat > ACK_TIMEOUT) return '{status: ST_TIMEOUT, dat: 32'h0};
        if (op == OP_WRITE) return '{status: ST_OK, dat: 32'h0};
        if (op != OP_POLL) return '{status: ST_OK, dat: rd[0]};
        for (int i = 0; i < POLL_LIMIT; i++) begin
            last = rd[i];
            if (((last ^ match) & mask) == 32'h0) return '{status: ST_OK, dat: last};
        end
        return '{status: ST_POLL_EXH, dat: last};
    endfunction

    // Wishbone slave: acks on the ack_lat-th cycle of each bus cycle (0 = never).
    initial begin
        int s_cnt;
        s_cnt = 0;
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.wb_cyc_o) begin
                s_cnt++;
                if (ack_lat != 0 && s_cnt == ack_lat) begin
                    bus.wb_ack_i = 1'b1;
                    bus.wb_dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
                end else begin
                    bus.wb_ack_i = 1'b0;
                    bus.wb_dat_i = 32'h5A5A_5A5A;
                end
            end else begin
                s_cnt        = 0;
                bus.wb_ack_i = 1'b0;
            end
        end
    end

    // Bus monitor: cycle lengths, gaps between cycles, output stability.
    initial begin
        int run_hi;
        int run_lo;
        run_hi = 0;
        run_lo = 0;
        forever begin
            @(negedge clk);
            if (bus.wb_cyc_o) begin
                if (run_lo > 0 && len_q.size() > 0) gap_q.push_back(run_lo);
                run_lo = 0;
                if (run_hi == 0) begin
                    seen_adr  = bus.wb_adr_o;
                    seen_wdat = bus.wb_dat_o;
                    seen_we   = bus.wb_we_o;
                end else if (seen_adr != bus.wb_adr_o || seen_wdat != bus.wb_dat_o ||
                             seen_we != bus.wb_we_o) begin
                    stab_err++;
                end
                if (bus.wb_stb_o !== 1'b1 || bus.wb_sel_o !== 4'hF) stab_err++;
                run_hi++;
            end else begin
                if (bus.wb_stb_o !== 1'b0) stab_err++;
                if (run_hi > 0) len_q.push_back(run_hi);
                run_hi = 0;
                run_lo++;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [ADR_W-1:0] adr,
                        input logic [31:0] dat, input logic [31:0] mask);
        int b;
        b = 0;
        @(negedge clk);
        while (!bus.req_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
            return;
        end
        len_q.delete();
        gap_q.delete();
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_adr   = adr;
        bus.req_dat   = dat;
        bus.req_mask  = mask;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic recv(input int hold);
        rsp_t e;
        int   b;
        b = 0;
        @(negedge clk);
        while (!bus.rsp_valid && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        if (!bus.rsp_valid) return;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_status", 32'(bus.rsp_status), 32'(e.status));
            chk("rsp_dat", bus.rsp_dat, e.dat);
            chk("busy_resp", 32'(busy), 32'd1);
            if (i < hold) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("req_ready_lo", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 chk("req_ready_hi", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= RESET_CYCLES; e++) begin
            @(posedge clk);
            #1;
            if (e < RESET_CYCLES) begin
                chk("core_rst_hold", 32'(core_rst), 32'd1);
                chk("req_ready_hold", 32'(bus.req_ready), 32'd0);
            end else begin
                chk("core_rst_drop", 32'(core_rst), 32'd0);
                chk("req_ready_up", 32'(bus.req_ready), 32'd1);
                chk("busy_idle", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic check_lens(input string tag, input int n, input int len);
        chk({tag, "_ncyc"}, 32'(len_q.size()), 32'(n));
        foreach (len_q[i]) chk({tag, "_cyclen"}, 32'(len_q[i]), 32'(len));
    endtask

    initial begin
        int stale;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_adr   = '0;
        bus.req_dat   = 32'h0;
        bus.req_mask  = 32'h0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_dat", bus.rsp_dat, 32'h0);
        chk("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
        chk("rst_cyc_stb_we", {29'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 32'h0);
        chk("rst_adr", 32'(bus.wb_adr_o), 32'h0);
        chk("rst_wdat", bus.wb_dat_o, 32'h0);
        release_reset();

        // Write, immediate ack
        ack_lat = 1;
        rd_q.delete();
        exp_q.push_back(model(OP_WRITE, 32'h1, 32'h0, rd_q, ack_lat));
        send(OP_WRITE, 8'h2C, 32'h0000_0001, 32'h0);
        recv(0);
        check_lens("wr", 1, 1);
        chk("wr_we", 32'(seen_we), 32'd1);
        chk("wr_adr", 32'(seen_adr), 32'h2C);
        chk("wr_wdat", seen_wdat, 32'h1);

        // Reserved op code behaves as a read; 3-cycle ack
        ack_lat = 3;
        rd_q = '{32'hA5A5_0003};
        exp_q.push_back(model(2'b11, 32'h0, 32'h0, rd_q, ack_lat));
        send(2'b11, 8'h10, 32'h0, 32'h0);
        recv(1);
        check_lens("rd", 1, 3);
        chk("rd_we", 32'(seen_we), 32'd0);

        // Poll that matches on the third read
        ack_lat = 1;
        rd_q = '{32'h0, 32'h0, 32'h1};
        exp_q.push_back(model(OP_POLL, 32'h1, 32'h1, rd_q, ack_lat));
        send(OP_POLL, 8'h30, 32'h1, 32'h1);
        recv(2);
        check_lens("poll", 3, 1);
        chk("poll_ngap", 32'(gap_q.size()), 32'd2);
        foreach (gap_q[i]) chk("poll_gap", 32'(gap_q[i]), 32'(POLL_GAP));
        chk("poll_adr", 32'(seen_adr), 32'h30);

        // Poll that never matches
        rd_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        exp_q.push_back(model(OP_POLL, 32'h1, 32'h1, rd_q, ack_lat));
        send(OP_POLL, 8'h30, 32'h1, 32'h1);
        recv(0);
        check_lens("exh", POLL_LIMIT, 1);
        chk("exh_unread", 32'(rd_q.size()), 32'd1);

        // Read with no ack -> timeout
        ack_lat = 0;
        rd_q.delete();
        exp_q.push_back(model(OP_READ, 32'h0, 32'h0, rd_q, ack_lat));
        send(OP_READ, 8'h44, 32'h0, 32'h0);
        recv(0);
        check_lens("tmo", 1, ACK_TIMEOUT);

        // Ack on the last allowed cycle wins over timeout
        ack_lat = ACK_TIMEOUT;
        rd_q = '{32'h1234_5678};
        exp_q.push_back(model(OP_READ, 32'h0, 32'h0, rd_q, ack_lat));
        send(OP_READ, 8'h48, 32'h0, 32'h0);
        recv(0);
        check_lens("late_ack", 1, ACK_TIMEOUT);

        // Reset mid-bus-cycle
        ack_lat = 0;
        send(OP_READ, 8'h50, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("mid_cyc_up", 32'(bus.wb_cyc_o), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_cyc_drop", {30'h0, bus.wb_cyc_o, bus.wb_stb_o}, 32'h0);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_core_rst", 32'(core_rst), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        release_reset();
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.wb_cyc_o !== 1'b0) stale++;
        end
        chk("no_stale_rsp", 32'(stale), 32'd0);

        // Normal operation after the reset
        ack_lat = 2;
        rd_q = '{32'hCAFE_0001};
        exp_q.push_back(model(OP_READ, 32'h0, 32'h0, rd_q, ack_lat));
        send(OP_READ, 8'h60, 32'h0, 32'h0);
        recv(0);
        check_lens("post_rst", 1, 2);

        chk("stability", 32'(stab_err), 32'd0);
        chk("sb_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
